tile_ram_arbiter: RTL and testbench

//  Owns the single port of the 40x30 tile RAM and shares it between VGA scanout and game logic.
//  - VGA: reads every cycle of active video, top priority.
//  - Game logic: tile reads and writes (pac-man moves, dots eaten), queued in a small FIFO.

---
 rtl/tile_ram_pkg.sv | 39 +++
 rtl/tile_req_fifo.sv | 64 ++++++
 rtl/tile_ram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tile_ram_pkg.sv
// rtl/tile_ram_pkg.sv - shared types and constants for the tile RAM arbiter
// Contents: RAM geometry, tile codes, game request struct, arbiter state encoding,
//           address range helper.
package tile_ram_pkg;

    localparam int ADDR_W         = 11;
    localparam int DATA_W         = 3;
    localparam int NUM_TILES      = 1200;
    localparam int ROW_TILES      = 40;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TILES - 1);

    typedef enum logic [DATA_W-1:0] {
        FAL      = 3'd0,
        FELFAL   = 3'd1,
        PACMAN   = 3'd2,
        UT       = 3'd4,
        PONT     = 3'd5,
        NAGYPONT = 3'd6
    } tile_code_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } tile_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_TILES);
    endfunction

endpackage

// File: rtl/tile_req_fifo.sv
// rtl/tile_req_fifo.sv - synchronous FIFO holding queued game requests
// Ports: clk, rst (sync, active-high); push_i/wdata_i write side; pop_i read side with
//        rdata_o showing the head entry combinationally; full_o, empty_o, count_o status.
// A push while full and a pop while empty are ignored. DEPTH must be a power of 2.
module tile_req_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tile_ram_arbiter.sv
// rtl/tile_ram_arbiter.sv - shares the single tile RAM port between VGA scanout and game logic
// Ports: clk, rst (sync, active-high);
//        vga_active/vga_addr -> vga_dout : scanout reads, highest priority;
//        req_valid/req_ready/req_we/req_addr/req_wdata : queued game requests;
//        rsp_valid/rsp_rdata : in-order read responses, one cycle after issue;
//        ram_addr/ram_we/ram_din/ram_dout : the RAM port (sync read, 1-cycle latency);
//        clr_start/clr_value/clr_busy : fill sweep, only when TILE_ARB_CLEAR_EN is defined.
// Macro TILE_ARB_CLEAR_EN adds the CLEAR state that fills all tiles with clr_value.
module tile_ram_arbiter
    import tile_ram_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_active,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_dout,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef TILE_ARB_CLEAR_EN
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tile_req_t     push_req;
    tile_req_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          game_issue;
    logic          fifo_drained;

    arb_state_t    state_q, state_d;
    logic          rsp_pend_q, rsp_pend_d;
    logic          rsp_zero_q, rsp_zero_d;

`ifdef TILE_ARB_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] clr_value_q, clr_value_d;
    logic              clr_write;
    logic              clr_accept;

    assign clr_busy   = (state_q == ST_CLEAR);
    assign clr_accept = clr_start && !clr_busy;
    assign req_ready  = !rst && !fifo_full && !clr_busy;
`else
    assign req_ready  = !rst && !fifo_full;
`endif

    assign push     = req_valid && req_ready;
    assign push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

    tile_req_fifo #(
        .WIDTH($bits(tile_req_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .wdata_i(push_req),
        .pop_i  (game_issue),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    // The queue runs dry after this cycle when the last entry leaves and nothing replaces it.
    assign fifo_drained = fifo_empty || (game_issue && (fifo_count == CW'(1)) && !push);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rsp_pend_q <= 1'b0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef TILE_ARB_CLEAR_EN
                if (clr_accept) begin
                    state_d = ST_CLEAR;
                end else
`endif
                if (!vga_active && !fifo_drained) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
`ifdef TILE_ARB_CLEAR_EN
                if (clr_accept) begin
                    state_d = ST_CLEAR;
                end else
`endif
                if (vga_active || fifo_drained) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef TILE_ARB_CLEAR_EN
            ST_CLEAR: begin
                if (!vga_active && (clr_addr_q == LAST_ADDR)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Port owner is picked every cycle. The first blank cycle already issues the FIFO head,
    // so there is no bubble between VGA release and game traffic.
    always_comb begin
        ram_addr   = head.addr;
        ram_we     = 1'b0;
        ram_din    = head.wdata;
        game_issue = 1'b0;
`ifdef TILE_ARB_CLEAR_EN
        clr_write  = 1'b0;
`endif
        if (vga_active) begin
            ram_addr = vga_addr;
        end else if (!rst) begin
`ifdef TILE_ARB_CLEAR_EN
            if (state_q == ST_CLEAR) begin
                ram_addr  = clr_addr_q;
                ram_we    = 1'b1;
                ram_din   = clr_value_q;
                clr_write = 1'b1;
            end else
`endif
            if (!fifo_empty) begin
                game_issue = 1'b1;
                ram_we     = head.we && addr_in_range(head.addr);
            end
        end
    end

    assign rsp_pend_d = game_issue && !head.we;
    assign rsp_zero_d = !addr_in_range(head.addr);

    assign rsp_valid  = rsp_pend_q;
    assign rsp_rdata  = rsp_zero_q ? '0 : ram_dout;
    assign vga_dout   = ram_dout;

`ifdef TILE_ARB_CLEAR_EN
    always_comb begin
        clr_addr_d  = clr_addr_q;
        clr_value_d = clr_value_q;
        if (clr_accept) begin
            clr_addr_d  = '0;
            clr_value_d = clr_value;
        end else if (clr_write) begin
            clr_addr_d  = clr_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr_q  <= '0;
            clr_value_q <= '0;
        end else begin
            clr_addr_q  <= clr_addr_d;
            clr_value_q <= clr_value_d;
        end
    end
`endif

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb/tb_tile_ram_arbiter.sv - directed self-checking bench for tile_ram_arbiter
module tb_tile_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_active;
    logic [10:0] vga_addr;
    logic [2:0]  vga_dout;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [10:0] req_addr;
    logic [2:0]  req_wdata;
    logic        rsp_valid;
    logic [2:0]  rsp_rdata;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [2:0]  ram_din;
    logic [2:0]  ram_dout;
`ifdef TILE_ARB_CLEAR_EN
    logic        clr_start;
    logic [2:0]  clr_value;
    logic        clr_busy;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] mem [2048];

    always #5 clk = ~clk;

    tile_ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .vga_active(vga_active),
        .vga_addr  (vga_addr),
        .vga_dout  (vga_dout),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef TILE_ARB_CLEAR_EN
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
`endif
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Sync-read RAM, preloaded with mem[i] = (i+3) mod 8.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [10:0] addr, input logic [2:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 3'((i + 3) % 8);
        rst = 1'b1; vga_active = 1'b0; vga_addr = '0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef TILE_ARB_CLEAR_EN
        clr_start = 1'b0; clr_value = '0;
`endif
        // Reset state
        @(negedge clk); #2;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        @(negedge clk); rst = 1'b0; #2;
        check("post_rst_req_ready", 32'(req_ready), 1);

        // 1: VGA owns the port, queued write waits for blanking
        @(negedge clk); vga_active = 1'b1; vga_addr = 11'd41; push_req(1'b1, 11'd41, 3'd5); #2;
        check("t1_vga_addr", 32'(ram_addr), 41);
        check("t1_vga_we", 32'(ram_we), 0);
        @(negedge clk); req_valid = 1'b0; #2;
        check("t1_hold_we", 32'(ram_we), 0);
        @(negedge clk); vga_active = 1'b0; #2;
        check("t1_wr_addr", 32'(ram_addr), 41);
        check("t1_wr_we", 32'(ram_we), 1);
        check("t1_wr_din", 32'(ram_din), 5);
        @(negedge clk); vga_active = 1'b1; #2;
        check("t1_no_rsp", 32'(rsp_valid), 0);
        @(negedge clk); vga_active = 1'b0; #2;
        check("t1_vga_dout", 32'(vga_dout), 5);

        // 2: back-to-back reads of 0,1,2 during blanking
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 3) push_req(1'b0, 11'(i), 3'd0);
            else req_valid = 1'b0;
            #2;
            if (i >= 1 && i <= 3) begin
                check("t2_ram_addr", 32'(ram_addr), 32'(i - 1));
                check("t2_ram_we", 32'(ram_we), 0);
            end
            if (i >= 2 && i <= 4) begin
                check("t2_rsp_valid", 32'(rsp_valid), 1);
                check("t2_rsp_rdata", 32'(rsp_rdata), 32'(i + 1));
            end
            if (i == 5) check("t2_rsp_done", 32'(rsp_valid), 0);
        end

        // 3: fill the FIFO while VGA is active, then drain
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); vga_active = 1'b1;
            if (k < 4) push_req(1'b1, 11'(100 + k), 3'(k + 1));
            else push_req(1'b1, 11'd200, 3'd7);
            #2;
            check("t3_fill_ready", 32'(req_ready), (k < 4) ? 1 : 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); vga_active = 1'b0; req_valid = 1'b0; #2;
            if (k < 4) begin
                check("t3_drain_addr", 32'(ram_addr), 32'(100 + k));
                check("t3_drain_we", 32'(ram_we), 1);
                check("t3_drain_din", 32'(ram_din), 32'(k + 1));
                check("t3_drain_ready", 32'(req_ready), (k == 0) ? 0 : 1);
            end else begin
                check("t3_no_extra", 32'(ram_we), 0);
            end
        end

        // 4: out-of-range write and read
        @(negedge clk); push_req(1'b1, 11'd1200, 3'd2); #2;
        @(negedge clk); push_req(1'b0, 11'd1200, 3'd0); #2;
        check("t4_oor_wr_we", 32'(ram_we), 0);
        @(negedge clk); req_valid = 1'b0; #2;
        check("t4_oor_rd_we", 32'(ram_we), 0);
        check("t4_wr_no_rsp", 32'(rsp_valid), 0);
        @(negedge clk); #2;
        check("t4_rsp_valid", 32'(rsp_valid), 1);
        check("t4_rsp_rdata", 32'(rsp_rdata), 0);

        // 5: reset with entries queued and a read response pending
        @(negedge clk); vga_active = 1'b1; push_req(1'b0, 11'd5, 3'd0); #2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); push_req(1'b1, 11'(300 + k), 3'd7); #2;
        end
        @(negedge clk); vga_active = 1'b0; req_valid = 1'b0; #2;
        check("t5_rd_addr", 32'(ram_addr), 5);
        @(negedge clk); vga_active = 1'b1; rst = 1'b1; #2;
        check("t5_pre_rst_rsp", 32'(rsp_valid), 1);
        check("t5_rst_ready", 32'(req_ready), 0);
        @(negedge clk); rst = 1'b0; vga_active = 1'b0; push_req(1'b0, 11'd2, 3'd0); #2;
        check("t5_flush_we", 32'(ram_we), 0);
        check("t5_flush_rsp", 32'(rsp_valid), 0);
        check("t5_ready", 32'(req_ready), 1);
        @(negedge clk); req_valid = 1'b0; #2;
        check("t5_new_addr", 32'(ram_addr), 2);
        check("t5_new_we", 32'(ram_we), 0);
        @(negedge clk); #2;
        check("t5_new_rsp", 32'(rsp_valid), 1);
        check("t5_new_rdata", 32'(rsp_rdata), 5);

`ifdef TILE_ARB_CLEAR_EN
        // 6: full clear sweep in a long blank window
        begin
            int n_wr = 0;
            int n_bad = 0;
            int cyc = 0;
            @(negedge clk); clr_start = 1'b1; clr_value = 3'd4; #2;
            @(negedge clk); clr_start = 1'b0; #2;
            while (clr_busy && cyc < 1400) begin
                if (!ram_we || ram_addr != 11'(n_wr) || ram_din != 3'd4 || req_ready) n_bad++;
                n_wr++;
                cyc++;
                @(negedge clk); #2;
            end
            check("t6_timeout", 32'(cyc < 1400), 1);
            check("t6_writes", 32'(n_wr), 1200);
            check("t6_bad_cycles", 32'(n_bad), 0);
            check("t6_busy_drop", 32'(clr_busy), 0);
            check("t6_ready_back", 32'(req_ready), 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
